// File: rtl/ecall_write_streamer_pkg.sv
// Shared definitions for the ecall write streamer: data word width and FSM state codes.
package ecall_write_streamer_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned BYTE_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_LOAD    = 3'd2;
  localparam state_t ST_PRESENT = 3'd3;
  localparam state_t ST_RELEASE = 3'd4;
  localparam state_t ST_FINISH  = 3'd5;

  function automatic logic state_is_busy(input state_t s);
    return (s == ST_FETCH) || (s == ST_LOAD) || (s == ST_PRESENT) || (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/ecall_write_streamer_sync_2ff.sv
// Two-flop synchronizer for inputs arriving asynchronously to clk.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ecall_write_streamer.sv
// Streams a CPU write-ecall buffer from data memory port B over a 4-phase valid/ack byte link.
// Optional ack timeout is enabled by defining ECALL_STREAM_TIMEOUT_EN.
module ecall_write_streamer
  import ecall_write_streamer_pkg::*;
#(
  parameter int unsigned DM_BITS        = 14,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WORD_W-1:0]  base_addr,
  input  logic [WORD_W-1:0]  len,
  output logic               done,
  output logic               busy,
  output logic               error,
  output logic               mem_rden,
  output logic [DM_BITS-1:0] mem_addr,
  input  logic [WORD_W-1:0]  mem_q,
  output logic [BYTE_W-1:0]  byte_data,
  output logic               byte_valid,
  input  logic               byte_ack,
  output logic [WORD_W-1:0]  sent_count
);

  if (TIMEOUT_CYCLES == 0 || DM_BITS == 0 || DM_BITS >= WORD_W) begin : g_bad_params
    $error("ecall_write_streamer: invalid DM_BITS or TIMEOUT_CYCLES");
  end

  state_t             state;
  logic [DM_BITS-1:0] base_q;
  logic [DM_BITS-1:0] offset;
  logic [WORD_W-1:0]  len_q;
  logic [WORD_W-1:0]  sent_next;
  logic               ack_s;
  logic               timed_out;
  logic               unused_bits;

  sync_2ff #(.WIDTH(1)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (byte_ack),
    .q     (ack_s)
  );

  assign mem_rden   = (state == ST_FETCH);
  assign mem_addr   = base_q + offset;
  assign byte_valid = (state == ST_PRESENT);
  assign done       = (state == ST_FINISH);
  assign busy       = state_is_busy(state);
  assign sent_next  = sent_count + 64'd1;

  assign unused_bits = ^{base_addr[WORD_W-1:DM_BITS], mem_q[WORD_W-1:BYTE_W]};

`ifdef ECALL_STREAM_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        waiting;
  logic        error_q;

  // Counter runs only while the FSM stays in a wait state; any transition clears it.
  assign waiting   = (state == ST_PRESENT && !ack_s) || (state == ST_RELEASE && ack_s);
  assign timed_out = waiting && (wait_cnt == TIMEOUT_CYCLES - 1);
  assign error     = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      wait_cnt <= waiting ? wait_cnt + 32'd1 : '0;
      if (state == ST_IDLE && start)
        error_q <= 1'b0;
      else if (timed_out)
        error_q <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      offset     <= '0;
      sent_count <= '0;
      byte_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q     <= base_addr[DM_BITS-1:0];
            len_q      <= len;
            offset     <= '0;
            sent_count <= '0;
            state      <= (len == '0) ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          byte_data <= mem_q[BYTE_W-1:0];
          state     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (ack_s)
            state <= ST_RELEASE;
          else if (timed_out)
            state <= ST_FINISH;
        end
        ST_RELEASE: begin
          if (!ack_s) begin
            offset     <= offset + DM_BITS'(1);
            sent_count <= sent_next;
            state      <= (sent_next == len_q) ? ST_FINISH : ST_FETCH;
          end else if (timed_out) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (!start)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecall_write_streamer.sv
// Directed self-checking bench for ecall_write_streamer with a registered memory and a delayed-ack receiver.
module tb_ecall_write_streamer;

  localparam int unsigned DM_BITS = 14;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [63:0]        base_addr = '0;
  logic [63:0]        len = '0;
  logic               done, busy, error, mem_rden, byte_valid;
  logic [DM_BITS-1:0] mem_addr;
  logic [63:0]        mem_q = '0;
  logic [7:0]         byte_data;
  logic               byte_ack = 1'b0;
  logic [63:0]        sent_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ecall_write_streamer #(
    .DM_BITS        (DM_BITS),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .done       (done),
    .busy       (busy),
    .error      (error),
    .mem_rden   (mem_rden),
    .mem_addr   (mem_addr),
    .mem_q      (mem_q),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ack   (byte_ack),
    .sent_count (sent_count)
  );

  logic [7:0] mem [0:(1<<DM_BITS)-1];

  always @(posedge clk)
    if (mem_rden) mem_q <= {56'hDEADBEEFCAFEF0, mem[mem_addr]};

  logic [DM_BITS-1:0] addr_log[$];
  logic [7:0]         data_log[$];
  int                 rden_cnt = 0;
  int                 strobe_cnt = 0;
  logic               prev_valid = 1'b0;

  always @(negedge clk) begin
    if (mem_rden) begin
      addr_log.push_back(mem_addr);
      rden_cnt++;
    end
    if (byte_valid && !prev_valid) begin
      data_log.push_back(byte_data);
      strobe_cnt++;
    end
    prev_valid = byte_valid;
  end

  // Receiver: follows byte_valid with ack after ack_dly+1 cycles of mismatch.
  int ack_dly = 2;
  int ack_cnt = 0;
  logic ack_en = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !ack_en) begin
        byte_ack = 1'b0;
        ack_cnt  = 0;
      end else if (byte_ack != byte_valid) begin
        if (ack_cnt >= ack_dly) begin
          byte_ack = byte_valid;
          ack_cnt  = 0;
        end else begin
          ack_cnt++;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    rden_cnt   = 0;
    strobe_cnt = 0;
  endtask

  task automatic start_xfer(input logic [63:0] b, input logic [63:0] l);
    @(negedge clk);
    base_addr = b;
    len       = l;
    start     = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {63'd0, done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int saved;
    int vcnt;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_rden", {63'd0, mem_rden}, 64'd0);
    check("rst_valid", {63'd0, byte_valid}, 64'd0);
    check("rst_data", {56'd0, byte_data}, 64'd0);
    check("rst_addr", {50'd0, mem_addr}, 64'd0);
    check("rst_sent", sent_count, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three bytes from 0x10
    mem[14'h10] = 8'hA1;
    mem[14'h11] = 8'hB2;
    mem[14'h12] = 8'hC3;
    clear_logs();
    start_xfer(64'h10, 64'd3);
    @(negedge clk);
    check("t1_rden_lat", {63'd0, mem_rden}, 64'd1);
    check("t1_addr0", {50'd0, mem_addr}, 64'h10);
    check("t1_busy", {63'd0, busy}, 64'd1);
    repeat (2) @(negedge clk);
    check("t1_valid_lat", {63'd0, byte_valid}, 64'd1);
    check("t1_data0", {56'd0, byte_data}, 64'hA1);
    wait_done("t1", 200);
    check("t1_sent", sent_count, 64'd3);
    check("t1_busy_end", {63'd0, busy}, 64'd0);
    check("t1_error", {63'd0, error}, 64'd0);
    check("t1_naddr", 64'(addr_log.size()), 64'd3);
    check("t1_addr1", {50'd0, addr_log[1]}, 64'h11);
    check("t1_addr2", {50'd0, addr_log[2]}, 64'h12);
    check("t1_ndata", 64'(data_log.size()), 64'd3);
    check("t1_d1", {56'd0, data_log[1]}, 64'hB2);
    check("t1_d2", {56'd0, data_log[2]}, 64'hC3);
    repeat (3) @(negedge clk);
    check("t1_done_hold", {63'd0, done}, 64'd1);
    check("t1_no_retrig", 64'(rden_cnt), 64'd3);
    start = 1'b0;
    @(negedge clk);
    check("t1_done_drop", {63'd0, done}, 64'd0);

    // Zero length
    clear_logs();
    start_xfer(64'h40, 64'd0);
    @(negedge clk);
    check("t2_done_lat", {63'd0, done}, 64'd1);
    check("t2_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    check("t2_no_rden", 64'(rden_cnt), 64'd0);
    check("t2_no_strobe", 64'(strobe_cnt), 64'd0);
    start = 1'b0;
    @(negedge clk);

    // Address wrap, upper base bits ignored
    mem[14'h3FFF] = 8'h5A;
    mem[14'h0000] = 8'h6B;
    clear_logs();
    start_xfer(64'hFFFF_0000_0000_3FFF, 64'd2);
    wait_done("t3", 200);
    check("t3_addr0", {50'd0, addr_log[0]}, 64'h3FFF);
    check("t3_addr1", {50'd0, addr_log[1]}, 64'h0000);
    check("t3_d0", {56'd0, data_log[0]}, 64'h5A);
    check("t3_d1", {56'd0, data_log[1]}, 64'h6B);
    check("t3_sent", sent_count, 64'd2);
    start = 1'b0;
    @(negedge clk);

    // Start dropped during first byte
    mem[14'h20] = 8'h11;
    mem[14'h21] = 8'h22;
    mem[14'h22] = 8'h33;
    mem[14'h23] = 8'h44;
    clear_logs();
    start_xfer(64'h20, 64'd4);
    n = 0;
    while (strobe_cnt < 1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t4_first_strobe", 64'(strobe_cnt), 64'd1);
    start = 1'b0;
    wait_done("t4", 400);
    check("t4_sent", sent_count, 64'd4);
    check("t4_strobes", 64'(strobe_cnt), 64'd4);
    check("t4_d3", {56'd0, data_log[3]}, 64'h44);
    @(negedge clk);
    check("t4_done_drop", {63'd0, done}, 64'd0);
    repeat (3) @(negedge clk);
    check("t4_idle", {63'd0, busy}, 64'd0);
    check("t4_no_retrig", 64'(rden_cnt), 64'd4);

    // Reset during PRESENT of byte 2 of 5
    mem[14'h30] = 8'h71;
    mem[14'h31] = 8'h72;
    mem[14'h32] = 8'h73;
    mem[14'h33] = 8'h74;
    mem[14'h34] = 8'h75;
    clear_logs();
    start_xfer(64'h30, 64'd5);
    n = 0;
    while (strobe_cnt < 2 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_second_strobe", 64'(strobe_cnt), 64'd2);
    check("t5_in_present", {63'd0, byte_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_valid", {63'd0, byte_valid}, 64'd0);
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_done", {63'd0, done}, 64'd0);
    check("t5_rden", {63'd0, mem_rden}, 64'd0);
    check("t5_data", {56'd0, byte_data}, 64'd0);
    check("t5_sent", sent_count, 64'd0);
    check("t5_addr", {50'd0, mem_addr}, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saved = strobe_cnt;
    repeat (10) @(negedge clk);
    check("t5_no_strobe", 64'(strobe_cnt), 64'(saved));
    check("t5_idle", {63'd0, busy}, 64'd0);

`ifdef ECALL_STREAM_TIMEOUT_EN
    // Ack never given
    ack_en = 1'b0;
    clear_logs();
    start_xfer(64'h10, 64'd3);
    n = 0;
    while (!byte_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    vcnt = 0;
    while (byte_valid && vcnt < 100) begin
      vcnt++;
      @(negedge clk);
    end
    check("t6_valid_cycles", 64'(vcnt), 64'd20);
    check("t6_error", {63'd0, error}, 64'd1);
    check("t6_done", {63'd0, done}, 64'd1);
    check("t6_sent", sent_count, 64'd0);
    start  = 1'b0;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
`else
    vcnt = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
